// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART on the CPU data bus: TXD/RXD/CON registers at 0x40000018..0x40000020,
// independent TX and RX state machines, and a level interrupt from the sticky done/ready flags.
module uart_peripheral #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irqout
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Bus decode
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign sel_txd = (addr == ADDR_TXD);
    assign sel_rxd = (addr == ADDR_RXD);
    assign sel_con = (addr == ADDR_CON);
    assign wr_txd  = wr & sel_txd;
    assign wr_con  = wr & sel_con;
    assign rd_rxd  = rd & sel_rxd;
    assign rd_con  = rd & sel_con;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    // ---------------- transmitter ----------------
    uart_state_t      tx_state, tx_state_nx;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]       tx_bit, tx_bit_nx;
    logic [7:0]       tx_shift, tx_shift_nx;
    logic [7:0]       tx_hold, tx_hold_nx;
    logic             tx_line, tx_line_nx;
    logic             tx_done_evt;
    logic             tx_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx_hold  <= tx_hold_nx;
            tx_line  <= tx_line_nx;
        end
    end

    // Line level is registered from the next state so it changes together with the FSM
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx_hold_nx  = tx_hold;
        tx_line_nx  = 1'b1;
        tx_done_evt = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                if (wr_txd) begin
                    tx_hold_nx  = wdata[7:0];
                    tx_shift_nx = wdata[7:0];
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = ST_DATA;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) begin
                        tx_state_nx = ST_STOP;
                    end else begin
                        tx_bit_nx = tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = ST_IDLE;
                    tx_done_evt = 1'b1;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_nx = ST_IDLE;
        endcase
        case (tx_state_nx)
            ST_START: tx_line_nx = 1'b0;
            ST_DATA:  tx_line_nx = tx_shift_nx[0];
            default:  tx_line_nx = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != ST_IDLE);
    assign uart_tx = tx_line;

    // ---------------- receiver ----------------
    logic             rx_sync1, rx_sync2, rx_prev;
    uart_state_t      rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       rx_bit, rx_bit_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic [7:0]       rx_data, rx_data_nx;
    logic             rx_ok_evt, rx_ferr_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_data  <= rx_data_nx;
        end
    end

    // Start needs a high-to-low transition, so a line stuck low after a framing error cannot retrigger
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_data_nx  = rx_data;
        rx_ok_evt   = 1'b0;
        rx_ferr_evt = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                if (!rx_sync2 && rx_prev) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_nx = '0;
                    rx_bit_nx = '0;
                    rx_state_nx = rx_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_nx = ST_STOP;
                    end else begin
                        rx_bit_nx = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = ST_IDLE;
                    if (rx_sync2) begin
                        rx_data_nx = rx_shift;
                        rx_ok_evt  = 1'b1;
                    end else begin
                        rx_ferr_evt = 1'b1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    // ---------------- control / status ----------------
    logic tx_irq_en, rx_irq_en;
    logic tx_done, rx_ready, overrun, frame_err;

    // Set events take priority over read-side clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_done   <= 1'b0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_con) begin
                tx_irq_en <= wdata[0];
                rx_irq_en <= wdata[1];
            end
            tx_done   <= tx_done_evt | (tx_done & ~rd_con);
            rx_ready  <= rx_ok_evt | (rx_ready & ~rd_rxd);
            overrun   <= (rx_ok_evt & rx_ready) | (overrun & ~rd_con);
            frame_err <= rx_ferr_evt | (frame_err & ~rd_con);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_txd) begin
                rdata = {24'b0, tx_hold};
            end else if (sel_rxd) begin
                rdata = {24'b0, rx_data};
            end else if (sel_con) begin
                rdata = {25'b0, frame_err, overrun, tx_busy, rx_ready, tx_done, rx_irq_en, tx_irq_en};
            end
        end
    end

    assign irqout = (tx_done & tx_irq_en) | (rx_ready & rx_irq_en);

endmodule

// File: tb/tb_uart_peripheral.sv
// Scoreboard bench for uart_peripheral at DIV=16: TX line levels and RX bytes are queued when
// stimulus is driven and compared as the DUT produces them; CON is checked against a flag model.
module tb_uart_peripheral;

    localparam logic [31:0] A_DIG = 32'h4000_0014;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_OUT = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irqout;

    uart_peripheral #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .irqout  (irqout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic       tx_q[$];
    logic [7:0] rx_q[$];

    // Reference model of the register-visible state
    logic       m_txie = 1'b0, m_rxie = 1'b0;
    logic       m_txdone = 1'b0, m_rxr = 1'b0, m_ovr = 1'b0, m_fer = 1'b0;
    logic [7:0] m_rxdata = 8'h00;
    logic [7:0] m_hold = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] con_exp();
        return {25'b0, m_fer, m_ovr, 1'b0, m_rxr, m_txdone, m_rxie, m_txie};
    endfunction

    function automatic logic irq_exp();
        return (m_txdone & m_txie) | (m_rxr & m_rxie);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        cyc();
        wr = 1'b0; addr = '0; wdata = '0;
        if (a == A_CON) {m_rxie, m_txie} = d[1:0];
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        cyc();
        rd = 1'b0; addr = '0;
    endtask

    task automatic con_check(input string tag);
        logic [31:0] v;
        bus_read(A_CON, v);
        check(tag, v, con_exp());
        m_txdone = 1'b0; m_ovr = 1'b0; m_fer = 1'b0;
    endtask

    task automatic rxd_check(input string tag);
        logic [31:0] v;
        logic [7:0]  e;
        bus_read(A_RXD, v);
        e = (rx_q.size() != 0) ? rx_q.pop_front() : m_rxdata;
        check(tag, v, {24'b0, e});
        m_rxr = 1'b0;
    endtask

    // Sends one byte and checks the first and last cycle of every bit; inj>=0 issues a TXD write mid-frame
    task automatic tx_frame(input logic [7:0] d, input int inj);
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
        tx_q.push_back(1'b1);
        bus_write(A_TXD, {24'b0, d});
        m_hold = d;
        for (int t = 0; t < 160; t++) begin
            if (t == inj) begin
                addr = A_TXD; wdata = 32'h3C; wr = 1'b1;
            end
            if ((t % 16 == 0) || (t % 16 == 15))
                check($sformatf("tx_%02h_bit%0d_t%0d", d, t / 16, t), 32'(uart_tx), 32'(tx_q[0]));
            if (t % 16 == 15) void'(tx_q.pop_front());
            if (t == 159) check("tx_irq_before_done", 32'(irqout), 32'(irq_exp()));
            cyc();
            wr = 1'b0; addr = '0; wdata = '0;
        end
        m_txdone = 1'b1;
        check("tx_done_irq", 32'(irqout), 32'(irq_exp()));
        check("tx_idle_line", 32'(uart_tx), 32'd1);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            if (m_rxr) m_ovr = 1'b1;
            m_rxr = 1'b1;
            m_rxdata = d;
            rx_q.delete();
            rx_q.push_back(d);
        end else begin
            m_fer = 1'b1;
        end
        uart_rx = 1'b0;
        repeat (16) cyc();
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (16) cyc();
        end
        uart_rx = stop;
        repeat (16) cyc();
        uart_rx = 1'b1;
        repeat (16) cyc();
    endtask

    initial begin
        logic [31:0] v;

        // Reset, then reset again in the middle of a frame
        repeat (3) cyc();
        check("rst_tx_line", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irqout), 32'd0);
        reset = 1'b0;
        cyc();
        bus_write(A_TXD, 32'h77);
        repeat (5) cyc();
        check("pre_reset_start_low", 32'(uart_tx), 32'd0);
        reset = 1'b1;
        cyc();
        check("midframe_reset_line", 32'(uart_tx), 32'd1);
        reset = 1'b0;
        cyc();
        con_check("con_after_reset");
        bus_read(A_TXD, v);
        check("txd_after_reset", v, 32'h0);
        check("irq_after_reset", 32'(irqout), 32'd0);
        bus_read(A_DIG, v);
        check("unmapped_dig", v, 32'h0);
        bus_read(A_OUT, v);
        check("unmapped_above", v, 32'h0);

        // Plain TX frame with tx interrupt enabled
        bus_write(A_CON, 32'h1);
        tx_frame(8'hA5, -1);
        addr = A_TXD;
        #1 check("rdata_zero_no_rd", rdata, 32'h0);
        addr = '0;
        con_check("con_tx_done");
        check("irq_after_con_read", 32'(irqout), 32'd0);

        // TXD write while busy must not disturb the frame or the holding register
        tx_frame(8'hA5, 5);
        bus_read(A_TXD, v);
        check("txd_hold_after_busy_write", v, {24'b0, m_hold});
        con_check("con_tx_done2");

        // RX frame with rx interrupt enabled
        bus_write(A_CON, 32'h2);
        rx_frame(8'h5A, 1'b1);
        check("rx_irq_set", 32'(irqout), 32'(irq_exp()));
        rxd_check("rxd_5a");
        check("rx_irq_cleared", 32'(irqout), 32'(irq_exp()));
        con_check("con_after_rxd_read");

        // Overrun: two frames without reading RXD
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        con_check("con_overrun");
        con_check("con_overrun_cleared");
        rxd_check("rxd_22");

        // Short glitch produces no flags
        uart_rx = 1'b0;
        repeat (3) cyc();
        uart_rx = 1'b1;
        repeat (40) cyc();
        con_check("con_after_glitch");

        // Framing error leaves rx_ready and rx_data alone
        rx_frame(8'h33, 1'b1);
        rx_frame(8'h99, 1'b0);
        check("irq_during_ferr", 32'(irqout), 32'(irq_exp()));
        con_check("con_frame_err");
        rxd_check("rxd_kept_33");
        con_check("con_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
